// File: rtl/a2n_word_deserializer.sv
// a2n_word_deserializer
// Receive stage for one ASIC-to-FPGA link. It synchronizes the async valid/data
// pins, samples one bit per BIT_EN strobe, assembles MSB-first words and buffers
// them in a first-word-fall-through FIFO with a valid/ready output.
// Optional feature macro: A2N_PARITY_EN (adds a trailing even-parity bit per word).
module a2n_word_deserializer #(
    parameter int WORD_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int ERR_W      = 8
) (
    input  logic              SYSCLK,
    input  logic              NSYSRESET,
    input  logic              A2N_VALID,
    input  logic              A2N_DATA,
    input  logic              BIT_EN,
    input  logic              ENABLE,
    input  logic              CLR_STATUS,
    output logic [WORD_W-1:0] WORD_DATA,
    output logic              WORD_VALID,
    input  logic              WORD_READY,
    output logic [ERR_W-1:0]  FRAME_ERR_CNT,
    output logic              OVERFLOW
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(WORD_W + 1);

`ifdef A2N_PARITY_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_PARITY = 2'd2} state_t;

    // Even parity: the transmitted parity bit equals the XOR of the data bits.
    function automatic logic even_parity(input logic [WORD_W-1:0] w);
        return ^w;
    endfunction
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1} state_t;
`endif

    logic              valid_meta_r, valid_sync_r;
    logic              data_meta_r, data_sync_r;
    state_t            state_r;
    logic [WORD_W-1:0] shift_r;
    logic [CW-1:0]     bit_cnt_r;
    logic              push_r;
    logic [WORD_W-1:0] push_word_r;
    logic [ERR_W-1:0]  err_cnt_r;
    logic              frame_err_s;
    logic [WORD_W-1:0] shift_nxt_s;
    logic              last_bit_s;

    logic [WORD_W-1:0] mem_r [FIFO_DEPTH];
    logic [AW:0]       wr_ptr_r, rd_ptr_r;
    logic [WORD_W-1:0] word_data_r;
    logic              word_valid_r;
    logic              overflow_r;
    logic              full_s, pop_s, wr_en_s, ovf_ev_s;
    logic [AW:0]       wr_nxt_s, rd_nxt_s;
    logic [WORD_W-1:0] head_nxt_s;

    assign shift_nxt_s = {shift_r[WORD_W-2:0], data_sync_r};
    assign last_bit_s  = (bit_cnt_r == CW'(WORD_W - 1));

    // Two-flop synchronizers for the asynchronous link pins.
    always_ff @(posedge SYSCLK) begin
        if (!NSYSRESET) begin
            valid_meta_r <= 1'b0;
            valid_sync_r <= 1'b0;
            data_meta_r  <= 1'b0;
            data_sync_r  <= 1'b0;
        end else begin
            valid_meta_r <= A2N_VALID;
            valid_sync_r <= valid_meta_r;
            data_meta_r  <= A2N_DATA;
            data_sync_r  <= data_meta_r;
        end
    end

    // Frame error: valid lost mid-word, or (with parity) a bad or missing parity bit.
    always_comb begin
        frame_err_s = 1'b0;
        if (ENABLE && BIT_EN) begin
            case (state_r)
                ST_SHIFT:  frame_err_s = !valid_sync_r && (bit_cnt_r != {CW{1'b0}});
`ifdef A2N_PARITY_EN
                ST_PARITY: frame_err_s = !valid_sync_r || (data_sync_r != even_parity(shift_r));
`endif
                default:   frame_err_s = 1'b0;
            endcase
        end else begin
            frame_err_s = 1'b0;
        end
    end

    // Bit-assembly FSM, registered push strobe and saturating frame-error counter.
    always_ff @(posedge SYSCLK) begin
        if (!NSYSRESET) begin
            state_r     <= ST_IDLE;
            shift_r     <= {WORD_W{1'b0}};
            bit_cnt_r   <= {CW{1'b0}};
            push_r      <= 1'b0;
            push_word_r <= {WORD_W{1'b0}};
            err_cnt_r   <= {ERR_W{1'b0}};
        end else begin
            push_r <= 1'b0;
            if (!ENABLE) begin
                state_r   <= ST_IDLE;
                bit_cnt_r <= {CW{1'b0}};
            end else if (BIT_EN) begin
                case (state_r)
                    ST_IDLE: begin
                        if (valid_sync_r) begin
                            shift_r   <= {{(WORD_W-1){1'b0}}, data_sync_r};
                            bit_cnt_r <= CW'(1);
                            state_r   <= ST_SHIFT;
                        end
                    end
                    ST_SHIFT: begin
                        if (valid_sync_r) begin
                            shift_r <= shift_nxt_s;
                            if (last_bit_s) begin
                                bit_cnt_r <= {CW{1'b0}};
`ifdef A2N_PARITY_EN
                                state_r   <= ST_PARITY;
`else
                                push_r      <= 1'b1;
                                push_word_r <= shift_nxt_s;
`endif
                            end else begin
                                bit_cnt_r <= bit_cnt_r + CW'(1);
                            end
                        end else begin
                            state_r   <= ST_IDLE;
                            bit_cnt_r <= {CW{1'b0}};
                        end
                    end
`ifdef A2N_PARITY_EN
                    ST_PARITY: begin
                        if (valid_sync_r && !frame_err_s) begin
                            push_r      <= 1'b1;
                            push_word_r <= shift_r;
                        end
                        state_r   <= valid_sync_r ? ST_SHIFT : ST_IDLE;
                        bit_cnt_r <= {CW{1'b0}};
                    end
`endif
                    default: begin
                        state_r   <= ST_IDLE;
                        bit_cnt_r <= {CW{1'b0}};
                    end
                endcase
            end
            if (CLR_STATUS) begin
                err_cnt_r <= {ERR_W{1'b0}};
            end else if (frame_err_s && (err_cnt_r != {ERR_W{1'b1}})) begin
                err_cnt_r <= err_cnt_r + ERR_W'(1);
            end
        end
    end

    // FIFO next-state: a full FIFO still accepts a push when a pop happens in the same cycle.
    always_comb begin
        full_s   = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        pop_s    = word_valid_r && WORD_READY;
        wr_en_s  = push_r && (!full_s || pop_s);
        ovf_ev_s = push_r && full_s && !pop_s;
        wr_nxt_s = wr_ptr_r + {{AW{1'b0}}, wr_en_s};
        rd_nxt_s = rd_ptr_r + {{AW{1'b0}}, pop_s};
        if (wr_en_s && (wr_ptr_r == rd_nxt_s)) begin
            head_nxt_s = push_word_r;
        end else begin
            head_nxt_s = mem_r[rd_nxt_s[AW-1:0]];
        end
    end

    // FIFO storage array.
    always_ff @(posedge SYSCLK) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_word_r;
        end
    end

    // FIFO pointers, registered head word/valid and sticky overflow flag.
    always_ff @(posedge SYSCLK) begin
        if (!NSYSRESET) begin
            wr_ptr_r     <= {(AW+1){1'b0}};
            rd_ptr_r     <= {(AW+1){1'b0}};
            word_valid_r <= 1'b0;
            word_data_r  <= {WORD_W{1'b0}};
            overflow_r   <= 1'b0;
        end else begin
            wr_ptr_r     <= wr_nxt_s;
            rd_ptr_r     <= rd_nxt_s;
            word_valid_r <= (wr_nxt_s != rd_nxt_s);
            if (wr_nxt_s != rd_nxt_s) begin
                word_data_r <= head_nxt_s;
            end
            if (CLR_STATUS) begin
                overflow_r <= 1'b0;
            end else if (ovf_ev_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign WORD_DATA     = word_data_r;
    assign WORD_VALID    = word_valid_r;
    assign FRAME_ERR_CNT = err_cnt_r;
    assign OVERFLOW      = overflow_r;

endmodule

// File: doc/a2n_word_deserializer.md
# a2n_word_deserializer

Receive-side stage for one ASIC-to-FPGA neural link. It synchronizes the asynchronous A2N_VALID/A2N_DATA pair into the SYSCLK domain, samples one bit per BIT_EN strobe, and assembles MSB-first words. Completed words are buffered in a small first-word-fall-through FIFO and delivered over a valid/ready handshake to the downstream feature/HDC pipeline. Mario_Libero instantiates one copy per link (links 0 and 1).

## Interface
- WORD_W, 16, bits per link word
- FIFO_DEPTH, 4, word buffer depth (power of two, ≥2)
- ERR_W, 8, width of saturating frame-error counter

- SYSCLK  in  1  system clock (20 MHz); the only clock
- NSYSRESET  in  1  reset; synchronous, active-low
- A2N_VALID  in  1  link frame-valid from ASIC, asynchronous
- A2N_DATA  in  1  link serial data from ASIC, asynchronous, MSB first
- BIT_EN  in  1  one-cycle sample strobe per link bit period, aligned to synchronized data
- ENABLE  in  1  receiver enable
- CLR_STATUS  in  1  one-cycle pulse; clears OVERFLOW and FRAME_ERR_CNT
- WORD_DATA  out  WORD_W  head-of-FIFO word
- WORD_VALID  out  1  WORD_DATA valid
- WORD_READY  in  1  consumer accepts word when WORD_VALID & WORD_READY
- FRAME_ERR_CNT  out  ERR_W  count of truncated frames, saturates at all-ones
- OVERFLOW  out  1  sticky; a completed word was dropped because the FIFO was full

## Operation
- Synchronizer: two flops per input (valid_s, data_s); reset to 0.
- FSM states: IDLE, SHIFT, and PARITY (only with A2N_PARITY_EN).
- IDLE: on BIT_EN & valid_s & ENABLE, shift data_s into bit 0 of the shift register, set bit_cnt=1, and go to SHIFT.
- SHIFT: on BIT_EN & valid_s, shift left and insert data_s; bit_cnt++.
  - When bit_cnt reaches WORD_W, the word is complete. Go to PARITY if compiled in; otherwise raise push and set bit_cnt=0.
  - The state stays SHIFT while valid stays high, so back-to-back words need no gap.
  - On BIT_EN & !valid_s with bit_cnt≠0: frame error. Discard the partial word, FRAME_ERR_CNT++ (saturating), go to IDLE.
  - On BIT_EN & !valid_s with bit_cnt=0: clean frame end. Go to IDLE, no error.
- Cycles without BIT_EN never change FSM state or data.
- ENABLE low: go to IDLE next cycle, discard any partial word with no error count. The FIFO keeps draining.
- FIFO, push of a completed word:
  - not full: write.
  - full and no pop in the same cycle: drop the word, set OVERFLOW.
  - full with a simultaneous pop: accept the word, no overflow.
- Pop happens on WORD_VALID & WORD_READY. WORD_DATA must hold stable while WORD_VALID=1 and WORD_READY=0.
- CLR_STATUS clears the status bits. If an increment or overflow coincides with CLR_STATUS, the clear wins.

## Timing
- Reset values: WORD_DATA=0, WORD_VALID=0, FRAME_ERR_CNT=0, OVERFLOW=0, FSM=IDLE, FIFO empty, bit_cnt=0.
- Reset asserted mid-word or with the FIFO non-empty: everything returns to reset values on the next edge, and buffered words are lost.
- Latency from the pin to a synchronized bit is 2 cycles. The BIT_EN generator absorbs this.
- Word latency: push is registered on the edge after the last bit's BIT_EN. WORD_VALID rises one cycle later, with the FIFO in fall-through mode.
- Throughput: one word per WORD_W BIT_EN strobes, which requires BIT_EN spacing of at least 2 cycles.
- FIFO full/empty are tracked with pointers that are one bit wider than the address. Pointers wrap modulo 2·FIFO_DEPTH.

## Configuration
- A2N_PARITY_EN:
  - Defined: after WORD_W data bits, one extra even-parity bit follows, carrying the XOR of the data bits.
  - On the PARITY state's BIT_EN, the word is pushed if parity matches. On a mismatch the word is discarded and FRAME_ERR_CNT increments.
  - If valid_s is low at the parity strobe, it is a frame error.
- Not defined: there is no PARITY state and words are pushed directly from SHIFT.

## Test plan
- Reset, then frame 16'hA5C3 with valid high for 16 strobes (strobe every 4 cycles) -> WORD_DATA=16'hA5C3, WORD_VALID 1 cycle after push, FRAME_ERR_CNT=0.
- Valid held for 48 strobes carrying 16'h0001, 16'h8000, 16'hFFFF, with WORD_READY=1 -> three words in order, no gaps, no errors.
- Valid drops after 9 bits -> no word; FRAME_ERR_CNT=1. A following full frame 16'h1234 is received correctly.
- WORD_READY=0 and 5 words sent -> first 4 buffered, 5th dropped, OVERFLOW=1. Drain gives the first 4 words in order. CLR_STATUS -> OVERFLOW=0.
- FIFO full with push and pop in the same cycle -> no overflow, and the new word appears last.
- NSYSRESET low at bit 8, then 16'hBEEF -> outputs at reset values, then 16'hBEEF clean. With A2N_PARITY_EN: a bad parity bit gives no word and FRAME_ERR_CNT+1.
